// File: rtl/proc72_pkg.sv
// Shared encodings for the proc72 control sequencer: states, opcodes, ALU codes and the
// registered control word.
package proc72_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam int unsigned OpNop   = 0;
  localparam int unsigned OpAdd   = 1;
  localparam int unsigned OpSub   = 2;
  localparam int unsigned OpAnd   = 3;
  localparam int unsigned OpOr    = 4;
  localparam int unsigned OpAddi  = 5;
  localparam int unsigned OpLoad  = 6;
  localparam int unsigned OpStore = 7;
  localparam int unsigned OpBeq   = 8;
  localparam int unsigned OpJump  = 9;
  localparam int unsigned OpHalt  = 15;

  localparam logic [2:0] AluNone = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluOr   = 3'd4;

  // Control word latched in DECODE; field order fixes the bit positions (msb first).
  typedef struct packed {
    logic [2:0] alu_op;
    logic       immediate_en;
    logic       is_mem;
    logic       is_load;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       illegal;
    logic       is_wb;
  } ctrl_word_t;

  localparam int unsigned CtrlW = $bits(ctrl_word_t);

  // Last wait-counter value before a handshake timeout fires.
  function automatic logic [7:0] wait_limit(int unsigned timeout);
    return 8'(timeout - 1);
  endfunction

endpackage

// File: rtl/proc72_ctrl_decode.sv
// Combinational opcode decoder for the proc72 control sequencer.
module proc72_ctrl_decode
  import proc72_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [2:0]          alu_op,
  output logic                immediate_en,
  output logic                is_mem,
  output logic                is_load,
  output logic                is_branch,
  output logic                is_jump,
  output logic                is_halt,
  output logic                illegal
);

  int unsigned op_val;

  always_comb begin
    op_val       = 32'(opcode);
    alu_op       = AluNone;
    immediate_en = 1'b0;
    is_mem       = 1'b0;
    is_load      = 1'b0;
    is_branch    = 1'b0;
    is_jump      = 1'b0;
    is_halt      = 1'b0;
    illegal      = 1'b0;
    case (op_val)
      OpNop:  ;
      OpAdd:  alu_op = AluAdd;
      OpSub:  alu_op = AluSub;
      OpAnd:  alu_op = AluAnd;
      OpOr:   alu_op = AluOr;
      OpAddi: begin
        alu_op       = AluAdd;
        immediate_en = 1'b1;
      end
      OpLoad: begin
        alu_op       = AluAdd;
        immediate_en = 1'b1;
        is_mem       = 1'b1;
        is_load      = 1'b1;
      end
      OpStore: begin
        alu_op       = AluAdd;
        immediate_en = 1'b1;
        is_mem       = 1'b1;
      end
      OpBeq: begin
        alu_op    = AluSub;
        is_branch = 1'b1;
      end
      OpJump: is_jump = 1'b1;
      OpHalt: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc72_control_fsm.sv
// Multi-cycle control sequencer for the 72-bit processor datapath.
// Optional performance counters are enabled by defining PROC72_PERF_CNT_EN.
module proc72_control_fsm
  import proc72_pkg::*;
#(
  parameter int unsigned INSTR_W     = 72,
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               imem_valid,
  input  logic               dmem_ready,
  input  logic               alu_zero,
  output logic               imem_req,
  output logic               pc_en,
  output logic               Branch_en,
  output logic               Jump_en,
  output logic               immediate_en,
  output logic [2:0]         alu_op,
  output logic               write_reg,
  output logic               write_datamem,
  output logic               read_datamem,
  output logic               illegal_op,
  output logic               mem_fault,
  output logic               halted,
  output logic [2:0]         state
`ifdef PROC72_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt
`endif
);

  localparam logic [7:0] WaitLast = wait_limit(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  ctrl_word_t            ctrl_q, ctrl_d, ctrl_dec;
  logic [7:0]            wait_q, wait_d;
  logic                  illegal_q, illegal_d;
  logic                  fault_q, fault_d;

  logic [2:0] dec_alu_op;
  logic       dec_imm, dec_mem, dec_load, dec_branch, dec_jump, dec_halt, dec_illegal;

  logic unused_instr;
  assign unused_instr = ^instr[INSTR_W-OPCODE_W-1:0];

  proc72_ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode      (opcode_q),
    .alu_op      (dec_alu_op),
    .immediate_en(dec_imm),
    .is_mem      (dec_mem),
    .is_load     (dec_load),
    .is_branch   (dec_branch),
    .is_jump     (dec_jump),
    .is_halt     (dec_halt),
    .illegal     (dec_illegal)
  );

  always_comb begin
    ctrl_dec              = '0;
    ctrl_dec.alu_op       = dec_alu_op;
    ctrl_dec.immediate_en = dec_imm;
    ctrl_dec.is_mem       = dec_mem;
    ctrl_dec.is_load      = dec_load;
    ctrl_dec.is_branch    = dec_branch;
    ctrl_dec.is_jump      = dec_jump;
    ctrl_dec.is_halt      = dec_halt;
    ctrl_dec.illegal      = dec_illegal;
    // Register-writing ALU ops are the ones with an ALU code that neither access memory nor branch.
    ctrl_dec.is_wb        = (dec_alu_op != AluNone) && !dec_mem && !dec_branch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      ctrl_q    <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_valid) begin
          opcode_d = instr[INSTR_W-1 -: OPCODE_W];
          state_d  = StDecode;
        end else if (wait_q == WaitLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        ctrl_d  = ctrl_dec;
        state_d = StExec;
      end
      StExec: begin
        if (ctrl_q.illegal) illegal_d = 1'b1;
        if (ctrl_q.is_halt)     state_d = StHalt;
        else if (ctrl_q.is_mem) state_d = StMem;
        else if (ctrl_q.is_wb)  state_d = StWb;
        else                    state_d = StFetch;
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = ctrl_q.is_load ? StWb : StFetch;
        end else if (wait_q == WaitLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StHalt;
    endcase
    wait_d = '0;
    if ((state_d == state_q) && ((state_q == StFetch) || (state_q == StMem))) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    imem_req      = 1'b0;
    pc_en         = 1'b0;
    Branch_en     = 1'b0;
    Jump_en       = 1'b0;
    immediate_en  = 1'b0;
    alu_op        = AluNone;
    write_reg     = 1'b0;
    write_datamem = 1'b0;
    read_datamem  = 1'b0;
    halted        = 1'b0;
    case (state_q)
      StFetch: imem_req = 1'b1;
      StExec: begin
        alu_op       = ctrl_q.alu_op;
        immediate_en = ctrl_q.immediate_en;
        if (ctrl_q.is_branch) begin
          pc_en     = 1'b1;
          Branch_en = alu_zero;
        end else if (ctrl_q.is_jump) begin
          pc_en   = 1'b1;
          Jump_en = 1'b1;
        end else if (!(ctrl_q.is_halt || ctrl_q.is_mem || ctrl_q.is_wb)) begin
          pc_en = 1'b1;
        end
      end
      StMem: begin
        read_datamem  = ctrl_q.is_load;
        write_datamem = ~ctrl_q.is_load;
        // A STORE retires in the cycle its write completes to keep its 4-cycle latency.
        pc_en         = dmem_ready & ~ctrl_q.is_load;
      end
      StWb: begin
        write_reg = 1'b1;
        pc_en     = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign mem_fault  = fault_q;
  assign state      = state_q;

`ifdef PROC72_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_en) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_proc72_control_fsm.sv
// Scoreboard bench for proc72_control_fsm: randomized programs are planned per cycle from the
// instruction latency rules, and a negedge monitor checks levels and retire events.
module tb_proc72_control_fsm;
  import proc72_pkg::*;

  localparam int MaxCyc = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] instr = '0;
  logic        imem_valid = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
  logic        imem_req, pc_en, Branch_en, Jump_en, immediate_en, write_reg;
  logic        write_datamem, read_datamem, illegal_op, mem_fault, halted;
  logic [2:0]  alu_op, state;
`ifdef PROC72_PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  always #5 clk = ~clk;

  proc72_control_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .imem_valid   (imem_valid),
    .dmem_ready   (dmem_ready),
    .alu_zero     (alu_zero),
    .imem_req     (imem_req),
    .pc_en        (pc_en),
    .Branch_en    (Branch_en),
    .Jump_en      (Jump_en),
    .immediate_en (immediate_en),
    .alu_op       (alu_op),
    .write_reg    (write_reg),
    .write_datamem(write_datamem),
    .read_datamem (read_datamem),
    .illegal_op   (illegal_op),
    .mem_fault    (mem_fault),
    .halted       (halted),
    .state        (state)
`ifdef PROC72_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .retire_cnt   (retire_cnt)
`endif
  );

  logic [16:0] all_out;
  assign all_out = {imem_req, pc_en, Branch_en, Jump_en, immediate_en, alu_op, write_reg,
                    write_datamem, read_datamem, illegal_op, mem_fault, halted, state};

  // Plan indexed by cycles since the first FETCH after reset.
  logic [71:0] st_instr [MaxCyc];
  logic        st_iv [MaxCyc];
  logic        st_dr [MaxCyc];
  logic        st_az [MaxCyc];
  // {imem_req, read, write, immediate_en, alu_op[2:0], illegal_op, halted, mem_fault}
  logic [9:0]  exp_lvl [MaxCyc];

  typedef struct {
    int   cyc;
    logic wr_reg;
    logic br;
    logic jp;
  } retire_t;
  retire_t exp_q[$];
  retire_t mon_r;

  int   plan_len, t, first_ill, halt_start, n_ret;
  logic fault_end;
  int   cyc;
  logic mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [9:0] mk(logic req, logic rd, logic wr, logic imm, logic [2:0] alu);
    return {req, rd, wr, imm, alu, 3'b000};
  endfunction

  function automatic logic [2:0] alu_for(int op);
    case (op)
      1, 5, 6, 7: return AluAdd;
      2, 8:       return AluSub;
      3:          return AluAnd;
      4:          return AluOr;
      default:    return AluNone;
    endcase
  endfunction

  task automatic plan_init();
    for (int k = 0; k < MaxCyc; k++) begin
      st_instr[k] = {$urandom, $urandom, 8'($urandom)};
      st_iv[k]    = 1'($urandom);
      st_dr[k]    = 1'($urandom);
      st_az[k]    = 1'($urandom);
      exp_lvl[k]  = '0;
    end
    t = 0; first_ill = -1; halt_start = MaxCyc; fault_end = 1'b0; n_ret = 0;
    exp_q.delete();
  endtask

  task automatic plan_fetch(input int op, input int fw);
    for (int k = 0; k <= fw; k++) begin
      exp_lvl[t+k] = mk(1'b1, 1'b0, 1'b0, 1'b0, AluNone);
      st_iv[t+k]   = (k == fw);
    end
    st_instr[t+fw] = {4'(op), 4'($urandom), $urandom, $urandom};
  endtask

  // azs: 0/1 forces alu_zero during EXEC, 2 leaves it random.
  task automatic add_instr(input int op, input int fw, input int mw, input int azs);
    int e;
    retire_t r;
    plan_fetch(op, fw);
    e = t + fw + 2;
    exp_lvl[e] = mk(1'b0, 1'b0, 1'b0, (op >= 5 && op <= 7), alu_for(op));
    if (azs != 2) st_az[e] = 1'(azs);
    r.wr_reg = 1'b0; r.br = 1'b0; r.jp = 1'b0;
    if (op == 6 || op == 7) begin
      for (int k = 0; k <= mw; k++) begin
        exp_lvl[e+1+k] = mk(1'b0, op == 6, op == 7, 1'b0, AluNone);
        st_dr[e+1+k]   = (k == mw);
      end
      r.cyc    = (op == 6) ? e + mw + 2 : e + mw + 1;
      r.wr_reg = (op == 6);
    end else if (op >= 1 && op <= 5) begin
      r.cyc    = e + 1;
      r.wr_reg = 1'b1;
    end else begin
      r.cyc = e;
      r.br  = (op == 8) && st_az[e];
      r.jp  = (op == 9);
      if (op >= 10 && first_ill < 0) first_ill = e;
    end
    exp_q.push_back(r);
    n_ret++;
    t = r.cyc + 1;
  endtask

  function automatic int rand_op();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 10) return r;
    return int'($urandom_range(10, 14));
  endfunction

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      add_instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
    end
  endtask

  task automatic end_halt(input int fw);
    plan_fetch(15, fw);
    halt_start = t + fw + 3;
  endtask

  task automatic end_mem_timeout(input int fw);
    int e;
    plan_fetch(7, fw);
    e = t + fw + 2;
    exp_lvl[e] = mk(1'b0, 1'b0, 1'b0, 1'b1, AluAdd);
    for (int k = 1; k <= 16; k++) begin
      exp_lvl[e+k] = mk(1'b0, 1'b0, 1'b1, 1'b0, AluNone);
      st_dr[e+k]   = 1'b0;
    end
    halt_start = e + 17;
    fault_end  = 1'b1;
  endtask

  task automatic end_fetch_timeout();
    for (int k = 0; k < 16; k++) begin
      exp_lvl[t+k] = mk(1'b1, 1'b0, 1'b0, 1'b0, AluNone);
      st_iv[t+k]   = 1'b0;
    end
    halt_start = t + 16;
    fault_end  = 1'b1;
  endtask

  task automatic plan_finish();
    plan_len = halt_start + 20;
    for (int k = 0; k < plan_len; k++) begin
      if (first_ill >= 0 && k > first_ill) exp_lvl[k][2] = 1'b1;
      if (k >= halt_start) begin
        exp_lvl[k][1] = 1'b1;
        exp_lvl[k][0] = fault_end;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(all_out), 64'd0);
    rst = 1'b0;
  endtask

  task automatic run_plan();
    for (int k = 0; k < plan_len; k++) begin
      @(posedge clk);
      #1;
      instr = st_instr[k]; imem_valid = st_iv[k]; dmem_ready = st_dr[k]; alu_zero = st_az[k];
      cyc = k;
      mon_on = 1'b1;
    end
    @(posedge clk);
    #1 mon_on = 1'b0;
    check("retire_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("levels", 64'({imem_req, read_datamem, write_datamem, immediate_en, alu_op,
                           illegal_op, halted, mem_fault}), 64'(exp_lvl[cyc]));
      if (pc_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: pc_en at cycle %0d, required no retire", cyc);
        end else begin
          mon_r = exp_q.pop_front();
          check("retire", {29'd0, 32'(cyc), write_reg, Branch_en, Jump_en},
                {29'd0, 32'(mon_r.cyc), mon_r.wr_reg, mon_r.br, mon_r.jp});
        end
      end else begin
        check("no_stray_strobe", 64'({write_reg, Branch_en, Jump_en}), 64'd0);
      end
    end
  end

  initial begin
    // Directed opener, then random traffic, ending on HALT.
    do_reset();
    plan_init();
    add_instr(1, 0, 0, 2);
    add_instr(6, 0, 2, 2);
    add_instr(8, 1, 0, 1);
    add_instr(8, 0, 0, 0);
    add_instr(9, 2, 0, 2);
    add_instr(0, 0, 0, 2);
    add_instr(7, 0, 1, 2);
    add_instr(5, 3, 0, 2);
    add_instr(12, 0, 0, 2);
    add_random(30);
    end_halt(int'($urandom_range(0, 3)));
    plan_finish();
    run_plan();
`ifdef PROC72_PERF_CNT_EN
    check("perf_cycle_cnt", 64'(cycle_cnt), 64'(halt_start + 1));
    check("perf_retire_cnt", 64'(retire_cnt), 64'(n_ret));
`endif

    // STORE whose data memory never answers.
    do_reset();
    plan_init();
    add_random(15);
    end_mem_timeout(0);
    plan_finish();
    run_plan();

    // Instruction memory never answers.
    do_reset();
    plan_init();
    add_random(5);
    end_fetch_timeout();
    plan_finish();
    run_plan();

    // Illegal opcode then HALT.
    do_reset();
    plan_init();
    add_instr(12, 0, 0, 2);
    add_instr(3, 1, 0, 2);
    end_halt(0);
    plan_finish();
    run_plan();

    // Asynchronous reset in the middle of a STORE's MEM phase.
    do_reset();
    @(posedge clk);
    #1;
    cyc = 0;
    instr = {4'd7, 68'd0}; imem_valid = 1'b1; dmem_ready = 1'b0;
    @(posedge clk);
    #1 imem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("store_in_mem", 64'({write_datamem, state}), 64'({1'b1, 3'd4}));
    #2 rst = 1'b1;
    #1;
    check("reset_async_outputs", 64'(all_out), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("post_reset_idle", 64'({state, imem_req}), 64'({3'd0, 1'b0}));
    @(posedge clk);
    #1;
    check("req_first_clk", 64'({state, imem_req}), 64'({3'd1, 1'b1}));
    @(posedge clk);
    #1;
    check("req_two_clks", 64'({imem_req, write_datamem}), 64'({1'b1, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
